// File: rtl/writeback_regfile.sv
// -----------------------------------------------------------------------------
// writeback_regfile
//
// Writeback stage of the 5-stage CPU together with the architectural register
// file. Selects the writeback value (ALU result or memory data), commits it to
// a 32x32 register file, serves two combinational read ports to decode,
// exposes the selected value for forwarding and counts retired writes.
//
// Optional feature (compile-time macro WB_BYPASS_EN):
//   defined   - write-through bypass: a read port addressing the register
//               being committed this cycle returns w_write_data immediately.
//   undefined - read ports return stored contents only (1-cycle latency).
//
// Ports:
//   clock           in   system clock, rising edge
//   reset           in   asynchronous, active-high reset
//   w_dst_reg       in   destination register index (MEM/WB)
//   w_reg_write     in   register write enable (MEM/WB)
//   w_mem_to_reg    in   write-data select: 0 = ALU result, 1 = memory data
//   w_alu_result    in   ALU result (MEM/WB)
//   w_mem_data      in   memory read data (MEM/WB)
//   d_rs_addr       in   decode read port A index
//   d_rt_addr       in   decode read port B index
//   d_rs_data       out  read port A data
//   d_rt_data       out  read port B data
//   w_write_data    out  selected writeback value, for forwarding
//   w_write_valid   out  commit to a nonzero register this cycle
//   w_retire_count  out  committed register writes since reset (wraps)
// -----------------------------------------------------------------------------
module writeback_regfile #(
  parameter int NUM_REGS = 32,  // index width is fixed at 5 bits; must be 32
  parameter int DATA_W   = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [4:0]        w_dst_reg,
  input  logic              w_reg_write,
  input  logic              w_mem_to_reg,
  input  logic [DATA_W-1:0] w_alu_result,
  input  logic [DATA_W-1:0] w_mem_data,
  input  logic [4:0]        d_rs_addr,
  input  logic [4:0]        d_rt_addr,
  output logic [DATA_W-1:0] d_rs_data,
  output logic [DATA_W-1:0] d_rt_data,
  output logic [DATA_W-1:0] w_write_data,
  output logic              w_write_valid,
  output logic [31:0]       w_retire_count
);

  // Entry 0 exists only so every 5-bit index is in range; it is never written
  // and is masked on read, so synthesis reduces it to constant zero.
  logic [DATA_W-1:0] regs [0:NUM_REGS-1];
  logic [31:0]       retire_count;

  assign w_write_data   = w_mem_to_reg ? w_mem_data : w_alu_result;
  // Gating with reset keeps a pending write from committing, bypassing or
  // counting while reset is held.
  assign w_write_valid  = w_reg_write & (w_dst_reg != 5'd0) & ~reset;
  assign w_retire_count = retire_count;

  // NOTE: the register array is reset explicitly so no X can ever be read
  // back; this costs a reset net on every entry but the spec forbids X.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (w_write_valid) begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of process ordering.
      regs[w_dst_reg] <= w_write_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      retire_count <= '0;
    end else if (w_write_valid) begin
      retire_count <= retire_count + 32'd1;  // wraps modulo 2^32
    end
  end

  // Read ports: r0 masking is applied last so it overrides any bypass.
  always_comb begin
    // NOTE: assign the default first so no path leaves the output unassigned,
    // which would otherwise infer a latch.
    d_rs_data = regs[d_rs_addr];
`ifdef WB_BYPASS_EN
    if (w_write_valid && (d_rs_addr == w_dst_reg)) d_rs_data = w_write_data;
`endif
    if (d_rs_addr == 5'd0) d_rs_data = '0;
  end

  always_comb begin
    d_rt_data = regs[d_rt_addr];
`ifdef WB_BYPASS_EN
    if (w_write_valid && (d_rt_addr == w_dst_reg)) d_rt_data = w_write_data;
`endif
    if (d_rt_addr == 5'd0) d_rt_data = '0;
  end

endmodule

// File: tb/tb_writeback_regfile.sv
// -----------------------------------------------------------------------------
// tb_writeback_regfile
//
// Directed self-checking bench for writeback_regfile. Inputs are driven 1 time
// unit after a rising edge; outputs are sampled well away from the edge.
// Expectations for the same-cycle read/write case follow WB_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_writeback_regfile;

  logic        clock;
  logic        reset;
  logic [4:0]  w_dst_reg;
  logic        w_reg_write;
  logic        w_mem_to_reg;
  logic [31:0] w_alu_result;
  logic [31:0] w_mem_data;
  logic [4:0]  d_rs_addr;
  logic [4:0]  d_rt_addr;
  logic [31:0] d_rs_data;
  logic [31:0] d_rt_data;
  logic [31:0] w_write_data;
  logic        w_write_valid;
  logic [31:0] w_retire_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_count;

  writeback_regfile #(.NUM_REGS(32), .DATA_W(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .w_dst_reg      (w_dst_reg),
    .w_reg_write    (w_reg_write),
    .w_mem_to_reg   (w_mem_to_reg),
    .w_alu_result   (w_alu_result),
    .w_mem_data     (w_mem_data),
    .d_rs_addr      (d_rs_addr),
    .d_rt_addr      (d_rt_addr),
    .d_rs_data      (d_rs_data),
    .d_rt_data      (d_rt_data),
    .w_write_data   (w_write_data),
    .w_write_valid  (w_write_valid),
    .w_retire_count (w_retire_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a write, take one rising edge, then drop the enable.
  task automatic commit(input logic [4:0] dst, input logic [31:0] alu,
                        input logic [31:0] mem, input logic m2r);
    w_dst_reg    = dst;
    w_alu_result = alu;
    w_mem_data   = mem;
    w_mem_to_reg = m2r;
    w_reg_write  = 1'b1;
    @(posedge clock);
    #1;
    w_reg_write  = 1'b0;
  endtask

  initial begin
    logic [31:0] v1;
    logic [31:0] v2;

    reset        = 1'b1;
    w_dst_reg    = 5'd5;
    w_reg_write  = 1'b1;
    w_mem_to_reg = 1'b0;
    w_alu_result = 32'h5555_5555;
    w_mem_data   = 32'h0;
    d_rs_addr    = 5'd5;
    d_rt_addr    = 5'd0;
    exp_count    = 32'd0;

    // Reset held across edges: nothing commits, valid is suppressed.
    repeat (2) @(posedge clock);
    #1;
    check("reset_valid", {31'd0, w_write_valid}, 32'd0);
    check("reset_rs5", d_rs_data, 32'd0);
    check("reset_count", w_retire_count, 32'd0);
    w_reg_write = 1'b0;
    reset = 1'b0;

    // 1. Async reset between edges.
    commit(5'd5, 32'h1234_5678, 32'h0, 1'b0);
    exp_count++;
    d_rs_addr = 5'd5;
    #1;
    check("t1_r5_written", d_rs_data, 32'h1234_5678);
    check("t1_count_one", w_retire_count, exp_count);
    reset = 1'b1;
    #1;
    check("t1_async_rs5", d_rs_data, 32'd0);
    check("t1_async_count", w_retire_count, 32'd0);
    #1;
    reset = 1'b0;
    exp_count = 32'd0;

    // 2. Write select; first edge after reset release commits normally.
    w_dst_reg    = 5'd3;
    w_alu_result = 32'hAAAA_0000;
    w_mem_data   = 32'h0000_BBBB;
    w_mem_to_reg = 1'b1;
    w_reg_write  = 1'b1;
    #1;
    check("t2_wdata_mem", w_write_data, 32'h0000_BBBB);
    check("t2_valid", {31'd0, w_write_valid}, 32'd1);
    commit(5'd3, 32'hAAAA_0000, 32'h0000_BBBB, 1'b1);
    exp_count++;
    d_rs_addr = 5'd3;
    #1;
    check("t2_r3_mem", d_rs_data, 32'h0000_BBBB);
    commit(5'd3, 32'hAAAA_0000, 32'h0000_BBBB, 1'b0);
    exp_count++;
    #1;
    check("t2_wdata_alu", w_write_data, 32'hAAAA_0000);
    check("t2_r3_alu", d_rs_data, 32'hAAAA_0000);
    check("t2_count", w_retire_count, exp_count);

    // 3. r0 protection.
    w_dst_reg    = 5'd0;
    w_alu_result = 32'hDEAD_BEEF;
    w_mem_to_reg = 1'b0;
    w_reg_write  = 1'b1;
    d_rs_addr    = 5'd0;
    d_rt_addr    = 5'd0;
    #1;
    check("t3_valid_r0", {31'd0, w_write_valid}, 32'd0);
    check("t3_rs_r0_pre", d_rs_data, 32'd0);
    @(posedge clock);
    #1;
    w_reg_write = 1'b0;
    check("t3_rs_r0", d_rs_data, 32'd0);
    check("t3_rt_r0", d_rt_data, 32'd0);
    check("t3_count", w_retire_count, exp_count);

    // 4. Same-cycle read/write to r7.
    commit(5'd7, 32'h1, 32'h0, 1'b0);
    exp_count++;
    w_dst_reg    = 5'd7;
    w_alu_result = 32'h2;
    w_mem_to_reg = 1'b0;
    w_reg_write  = 1'b1;
    d_rs_addr    = 5'd7;
    d_rt_addr    = 5'd7;
    #1;
`ifdef WB_BYPASS_EN
    check("t4_rs_pre", d_rs_data, 32'h2);
    check("t4_rt_pre", d_rt_data, 32'h2);
`else
    check("t4_rs_pre", d_rs_data, 32'h1);
    check("t4_rt_pre", d_rt_data, 32'h1);
`endif
    @(posedge clock);
    #1;
    w_reg_write = 1'b0;
    exp_count++;
    check("t4_rs_post", d_rs_data, 32'h2);
    check("t4_rt_post", d_rt_data, 32'h2);

    // 5. Counter wrap via backdoor preload.
    force dut.retire_count = 32'hFFFF_FFFE;
    #1;
    release dut.retire_count;
    #1;
    check("t5_preload", w_retire_count, 32'hFFFF_FFFE);
    commit(5'd9, 32'h9, 32'h0, 1'b0);
    check("t5_wrap_ffffffff", w_retire_count, 32'hFFFF_FFFF);
    commit(5'd9, 32'h9, 32'h0, 1'b0);
    check("t5_wrap_zero", w_retire_count, 32'h0000_0000);
    commit(5'd9, 32'h9, 32'h0, 1'b0);
    check("t5_wrap_one", w_retire_count, 32'h0000_0001);
    @(posedge clock);
    #1;
    check("t5_idle_hold", w_retire_count, 32'h0000_0001);
    exp_count = 32'h0000_0001;

    // 6. Full sweep: r[i] = i * 0x01010101.
    for (int i = 1; i < 32; i++) begin
      commit(5'(i), 32'(i) * 32'h0101_0101, 32'hFFFF_FFFF, 1'b0);
      exp_count++;
    end
    check("t6_count", w_retire_count, exp_count);
    for (int i = 0; i < 32; i++) begin
      d_rs_addr = 5'(i);
      d_rt_addr = 5'(31 - i);
      v1 = 32'(i) * 32'h0101_0101;
      v2 = 32'(31 - i) * 32'h0101_0101;
      #1;
      check($sformatf("t6_rs_r%0d", i), d_rs_data, v1);
      check($sformatf("t6_rt_r%0d", 31 - i), d_rt_data, v2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
